// File: rtl/enc_4b5b_pkg.sv
// enc_4b5b_pkg: 4b/5b code table, frame layout and transmitter state encoding,
// shared by the encode (transmit) and decode (receive) sides.
`default_nettype none

package enc_4b5b_pkg;

  localparam int FRAME_BITS = 12;
  localparam int CODE_BITS  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_t;

  // Codes written MSB..LSB; the line sends bit0 first.
  function automatic logic [CODE_BITS-1:0] code_4b5b(input logic [3:0] nibble);
    logic [CODE_BITS-1:0] code;
    code = 5'b11110;
    case (nibble)
      4'h0: code = 5'b11110;
      4'h1: code = 5'b01001;
      4'h2: code = 5'b10100;
      4'h3: code = 5'b10101;
      4'h4: code = 5'b01010;
      4'h5: code = 5'b01011;
      4'h6: code = 5'b01110;
      4'h7: code = 5'b01111;
      4'h8: code = 5'b10010;
      4'h9: code = 5'b10011;
      4'hA: code = 5'b10110;
      4'hB: code = 5'b10111;
      4'hC: code = 5'b11010;
      4'hD: code = 5'b11011;
      4'hE: code = 5'b11100;
      4'hF: code = 5'b11101;
      default: code = 5'b11110;
    endcase
    return code;
  endfunction

  // Frame bit 0 is the start bit, then low-nibble code, high-nibble code, stop bit.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [CODE_BITS-1:0] code_lo,
                                                        input logic [CODE_BITS-1:0] code_hi);
    return {1'b1, code_hi, code_lo, 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_4b5b.sv
// enc_4b5b: combinational 4-bit nibble to 5-bit line code encoder.
`default_nettype none

module enc_4b5b
  import enc_4b5b_pkg::*;
(
  input  logic [3:0]           nibble,
  output logic [CODE_BITS-1:0] code
);

  assign code = code_4b5b(nibble);

endmodule

`default_nettype wire

// File: rtl/enc_tx_9600.sv
// enc_tx_9600: 4b/5b framed serial transmitter (12-bit frame per byte, forced idle gap).
// Define ENC_TX_FIFO_EN to place a 4-entry byte FIFO between the handshake and the frame loader.
`default_nettype none

module enc_tx_9600
  import enc_4b5b_pkg::*;
#(
  parameter int CLK_DIV  = 5208,
  parameter int GAP_BITS = 12
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       TXD_5B,
  output logic       busy
);

  localparam int TIMER_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_BITS = (GAP_BITS > FRAME_BITS) ? GAP_BITS : FRAME_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_BITS - 1);

  tx_state_t             state;
  logic [TIMER_W-1:0]    bit_timer;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] frame;

  logic                  accept;
  logic                  have_byte;
  logic                  pending_next;
  logic                  timer_wrap;
  logic                  shift_done;
  logic                  gap_done;
  logic                  to_idle;
  logic [7:0]            load_byte;
  logic [CODE_BITS-1:0]  code_lo;
  logic [CODE_BITS-1:0]  code_hi;

  assign accept     = din_valid && din_ready;
  assign timer_wrap = (bit_timer == TIMER_LAST);
  assign shift_done = (state == ST_SHIFT) && timer_wrap && (bit_cnt == FRAME_LAST);
  assign gap_done   = (state == ST_GAP) && timer_wrap && (bit_cnt == GAP_LAST);
  assign to_idle    = ((state == ST_IDLE) && !have_byte) || gap_done;

  enc_4b5b u_enc_lo (
    .nibble (load_byte[3:0]),
    .code   (code_lo)
  );

  enc_4b5b u_enc_hi (
    .nibble (load_byte[7:4]),
    .code   (code_hi)
  );

`ifdef ENC_TX_FIFO_EN
  localparam int FIFO_DEPTH = 4;

  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_count;
  logic [2:0] count_next;
  logic       pop;

  assign pop = (state == ST_LOAD);

  always_comb begin
    count_next = fifo_count;
    if (accept && !pop) begin
      count_next = fifo_count + 3'd1;
    end else if (!accept && pop) begin
      count_next = fifo_count - 3'd1;
    end
  end

  // A byte pushed while empty is written on the accepting edge and read in LOAD,
  // so an idle block still starts the frame two clocks after the accept.
  assign have_byte    = (fifo_count != 3'd0) || accept;
  assign pending_next = (count_next != 3'd0);
  assign load_byte    = fifo_mem[rd_ptr];

  always_ff @(posedge CLK_50M) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      din_ready  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_count <= count_next;
      din_ready  <= (count_next != 3'(FIFO_DEPTH));
    end
  end
`else
  logic [7:0] hold;

  assign have_byte    = accept;
  assign pending_next = 1'b0;
  assign load_byte    = hold;

  // Ready only while the FSM rests in IDLE; offers during SHIFT/GAP simply wait.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      hold      <= 8'h00;
      din_ready <= 1'b0;
    end else begin
      if (accept) begin
        hold <= din;
      end
      din_ready <= to_idle;
    end
  end
`endif

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      bit_timer <= '0;
      bit_cnt   <= '0;
      frame     <= '1;
      TXD_5B    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      TXD_5B <= (state == ST_SHIFT) ? frame[bit_cnt[3:0]] : 1'b1;
      busy   <= to_idle ? pending_next : 1'b1;
      case (state)
        ST_IDLE: begin
          bit_timer <= '0;
          bit_cnt   <= '0;
          if (have_byte) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          frame     <= build_frame(code_lo, code_hi);
          bit_timer <= '0;
          bit_cnt   <= '0;
          state     <= ST_SHIFT;
        end
        ST_SHIFT, ST_GAP: begin
          if (timer_wrap) begin
            bit_timer <= '0;
            if (shift_done) begin
              bit_cnt <= '0;
              state   <= ST_GAP;
            end else if (gap_done) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            bit_timer <= bit_timer + TIMER_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
